// File: rtl/pipelined_addsub_bus.sv
// pipelined_addsub_bus
//   Elastic add/subtract pipeline with wrap or saturate modes, a global-stall valid/ready
//   handshake, and a tristate bus that is driven only when the result exceeds THRESHOLD.
//
// Parameters:
//   WIDTH      operand/result width (2..32)
//   STAGES     pipeline register depth (1..4)
//   THRESHOLD  bus is driven only when sum > THRESHOLD (unsigned)
//
// Ports:
//   clk, rst             clock, synchronous active-high reset
//   in_valid, in_ready   operand beat handshake (in_ready is combinational)
//   a, b, mode           operands; mode 00 add-wrap, 01 add-sat, 10 sub-wrap, 11 sub-sat
//   out_valid, out_ready result handshake
//   sum, ovf             result and carry/borrow of the oldest beat
//   drive_en, data       bus enable and shared tristate bus
//
// Optional feature (macro PIPELINED_ADDSUB_BUS_STATS_EN):
//   beat_count  output transfers, wraps at 65535
//   ovf_count   output transfers with ovf=1, saturates at 65535
//   stats_clr   synchronous clear of both counters, wins over increment
module pipelined_addsub_bus #(
    parameter int unsigned WIDTH     = 8,
    parameter int unsigned STAGES    = 2,
    parameter int unsigned THRESHOLD = 128
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [1:0]       mode,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             ovf,
    output logic             drive_en,
`ifdef PIPELINED_ADDSUB_BUS_STATS_EN
    output logic [15:0]      beat_count,
    output logic [15:0]      ovf_count,
    input  logic             stats_clr,
`endif
    inout  wire  [WIDTH-1:0] data
);

    logic [STAGES-1:0] v_q, v_d;
    logic [WIDTH-1:0]  sum_q [STAGES];
    logic [WIDTH-1:0]  sum_d [STAGES];
    logic [STAGES-1:0] ovf_q, ovf_d;

    logic             adv;
    logic [WIDTH:0]   r_full;
    logic             r_ovf;
    logic [WIDTH-1:0] r_sum;

    // Arithmetic on the beat presented this cycle; only registered when adv is high.
    always_comb begin
        r_full = '0;
        r_ovf  = 1'b0;
        if (mode[1]) begin
            r_full = {1'b0, a} - {1'b0, b};
            r_ovf  = (a < b);
        end else begin
            r_full = {1'b0, a} + {1'b0, b};
            r_ovf  = r_full[WIDTH];
        end
        if (mode[0] && r_ovf) begin
            r_sum = mode[1] ? '0 : '1;
        end else begin
            r_sum = r_full[WIDTH-1:0];
        end
    end

    // Global stall: the whole pipe moves only when the last stage can empty or is empty.
    assign adv      = out_ready | ~v_q[STAGES-1];
    assign in_ready = adv;

    always_comb begin
        v_d   = v_q;
        ovf_d = ovf_q;
        for (int i = 0; i < STAGES; i++) begin
            sum_d[i] = sum_q[i];
        end
        if (adv) begin
            v_d[0]   = in_valid;
            sum_d[0] = r_sum;
            ovf_d[0] = r_ovf;
            for (int i = 1; i < STAGES; i++) begin
                v_d[i]   = v_q[i-1];
                sum_d[i] = sum_q[i-1];
                ovf_d[i] = ovf_q[i-1];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            v_q   <= '0;
            ovf_q <= '0;
            for (int i = 0; i < STAGES; i++) begin
                sum_q[i] <= '0;
            end
        end else begin
            v_q   <= v_d;
            ovf_q <= ovf_d;
            for (int i = 0; i < STAGES; i++) begin
                sum_q[i] <= sum_d[i];
            end
        end
    end

    assign out_valid = v_q[STAGES-1];
    assign sum       = sum_q[STAGES-1];
    assign ovf       = ovf_q[STAGES-1];

    // Bus enable depends on registered state only.
    assign drive_en = out_valid && (32'(sum) > THRESHOLD);
    assign data     = drive_en ? sum : {WIDTH{1'bz}};

`ifdef PIPELINED_ADDSUB_BUS_STATS_EN
    logic [15:0] beat_count_q, beat_count_d;
    logic [15:0] ovf_count_q, ovf_count_d;
    logic        xfer;

    assign xfer = out_valid & out_ready;

    always_comb begin
        beat_count_d = beat_count_q;
        ovf_count_d  = ovf_count_q;
        if (stats_clr) begin
            beat_count_d = '0;
            ovf_count_d  = '0;
        end else if (xfer) begin
            beat_count_d = beat_count_q + 16'd1;
            if (ovf && (ovf_count_q != 16'hFFFF)) begin
                ovf_count_d = ovf_count_q + 16'd1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            beat_count_q <= '0;
            ovf_count_q  <= '0;
        end else begin
            beat_count_q <= beat_count_d;
            ovf_count_q  <= ovf_count_d;
        end
    end

    assign beat_count = beat_count_q;
    assign ovf_count  = ovf_count_q;
`endif

endmodule
